// File: rtl/led_blink_scheduler.sv
// Round-robin LED blink scheduler: four requesters share one LED and each owner gets
// a programmed number of 50%-duty blinks. Owners are separated by a forced idle gap.
module led_blink_scheduler #(
   parameter logic [31:0] HALF_PERIOD = 32'd50000000,
   parameter logic [31:0] GAP_CYCLES  = 32'd25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] req_count,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        busy,
   output logic        LED
);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t      state, state_nx;
   logic [1:0]  ptr, ptr_nx;
   logic [31:0] timer, timer_nx;
   logic [3:0]  remaining, remaining_nx;
   logic [3:0]  grant_nx, done_nx;
   logic        busy_nx, led_nx;

   logic        win_valid;
   logic [1:0]  win_idx;
   logic [3:0]  win_count;

   // Offsets are scanned farthest-first so the nearest requester after ptr is written last.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = ptr;
      for (int k = 4; k >= 1; k--) begin
         if (req[ptr + 2'(k)]) begin
            win_valid = 1'b1;
            win_idx   = ptr + 2'(k);
         end
      end
      win_count = req_count[{win_idx, 2'b00} +: 4];
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nx     = state;
      ptr_nx       = ptr;
      timer_nx     = timer;
      remaining_nx = remaining;
      grant_nx     = grant;
      done_nx      = 4'b0000;
      led_nx       = LED;

      case (state)
         IDLE: begin
            if (win_valid) begin
               ptr_nx       = win_idx;
               grant_nx     = 4'b0001 << win_idx;
               remaining_nx = win_count;
               timer_nx     = 32'd0;
               if (win_count != 4'd0) begin
                  state_nx = ON;
                  led_nx   = 1'b1;
               end else begin
                  state_nx = GAP;
                  led_nx   = 1'b0;
                  done_nx  = 4'b0001 << win_idx;
               end
            end
         end
         ON: begin
            if (!req[ptr]) begin
               state_nx = GAP;
               led_nx   = 1'b0;
               grant_nx = 4'b0000;
               timer_nx = 32'd0;
            end else if (timer == HALF_PERIOD - 32'd1) begin
               state_nx = OFF;
               led_nx   = 1'b0;
               timer_nx = 32'd0;
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         OFF: begin
            // A dropped owner request wins over the end-of-phase decision, so no done pulse.
            if (!req[ptr]) begin
               state_nx = GAP;
               led_nx   = 1'b0;
               grant_nx = 4'b0000;
               timer_nx = 32'd0;
            end else if (timer == HALF_PERIOD - 32'd1) begin
               timer_nx = 32'd0;
               if (remaining == 4'd1) begin
                  state_nx = GAP;
                  grant_nx = 4'b0000;
                  done_nx  = 4'b0001 << ptr;
               end else begin
                  state_nx     = ON;
                  led_nx       = 1'b1;
                  remaining_nx = remaining - 4'd1;
               end
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         GAP: begin
            grant_nx = 4'b0000;
            led_nx   = 1'b0;
            if (GAP_CYCLES == 32'd0 || timer == GAP_CYCLES - 32'd1) begin
               state_nx = IDLE;
               timer_nx = 32'd0;
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd3;
         timer     <= 32'd0;
         remaining <= 4'd0;
         grant     <= 4'b0000;
         done      <= 4'b0000;
         busy      <= 1'b0;
         LED       <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         timer     <= timer_nx;
         remaining <= remaining_nx;
         grant     <= grant_nx;
         done      <= done_nx;
         busy      <= busy_nx;
         LED       <= led_nx;
      end
   end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench: a timeline model (session start/end edges) predicts every output each
// cycle; directed scenarios pin the model with hand-computed values, then random traffic runs.
module tb_led_blink_scheduler;

   localparam int H = 4;
   localparam int G = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [15:0] req_count = 16'h0000;
   logic [3:0]  grant, done;
   logic        busy, led;

   int checks   = 0;
   int failures = 0;

   led_blink_scheduler #(.HALF_PERIOD(32'd4), .GAP_CYCLES(32'd2)) dut (
      .clk(clk), .rst(rst), .req(req), .req_count(req_count),
      .grant(grant), .done(done), .busy(busy), .LED(led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Model: n counts edges; a session owns the LED on edges [own_start, own_end), the idle
   // state is reached at edge idle_at, and done fires at edge done_at.
   int       n = 0, own_start = 0, own_end = 0, idle_at = 0, done_at = -1;
   int       owner = 0, cnt = 1;
   int       m_ptr = 3;

   task automatic model_reset();
      own_start = n;
      own_end   = n;
      idle_at   = n;
      done_at   = -1;
      cnt       = 1;
      m_ptr     = 3;
   endtask

   task automatic model_step();
      bit found;
      int w;
      n++;
      if (own_start <= n - 1 && n - 1 < own_end && !req[owner]) begin
         own_end = n;
         done_at = -1;
         idle_at = n + ((G > 0) ? G : 1);
      end else if (n - 1 >= idle_at && req != 4'b0000) begin
         found = 1'b0;
         w     = 0;
         for (int k = 1; k <= 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
               found = 1'b1;
               w     = (m_ptr + k) % 4;
            end
         end
         owner     = w;
         m_ptr     = w;
         cnt       = int'(req_count[4*w +: 4]);
         own_start = n;
         own_end   = n + 2 * H * cnt;
         done_at   = own_end;
         idle_at   = own_end + ((G > 0) ? G : 1);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      bit         own;
      logic [3:0] e_grant, e_done;
      logic       e_led, e_busy;
      if (!rst) begin
         own     = (own_start <= n) && (n < own_end);
         e_grant = (own || (cnt == 0 && n == own_start && n == done_at)) ? 4'(1 << owner) : 4'b0000;
         e_done  = (n == done_at) ? 4'(1 << owner) : 4'b0000;
         e_led   = own && (((n - own_start) % (2 * H)) < H);
         e_busy  = (n < idle_at);
         check("model_grant", 32'(grant), 32'(e_grant));
         check("model_done",  32'(done),  32'(e_done));
         check("model_led",   32'(led),   32'(e_led));
         check("model_busy",  32'(busy),  32'(e_busy));
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_led",   32'(led),   32'h0);
      check("reset_busy",  32'(busy),  32'h0);
      check("reset_done",  32'(done),  32'h0);
      #1 rst = 1'b0;
      @(negedge clk);

      // Owner 0 blinks twice.
      #1 req = 4'b0001; req_count = 16'h0002;
      @(negedge clk);
      check("blink2_grant_k", 32'(grant), 32'h1);
      check("blink2_led_k",   32'(led),   32'h1);
      for (int j = 1; j <= 18; j++) begin
         @(negedge clk);
         case (j)
            3:  check("blink2_led_k3", 32'(led), 32'h1);
            4:  check("blink2_led_k4", 32'(led), 32'h0);
            8:  check("blink2_led_k8", 32'(led), 32'h1);
            12: check("blink2_led_k12", 32'(led), 32'h0);
            15: check("blink2_grant_k15", 32'(grant), 32'h1);
            16: begin
               check("blink2_done_k16",  32'(done),  32'h1);
               check("blink2_grant_k16", 32'(grant), 32'h0);
               check("blink2_busy_k16",  32'(busy),  32'h1);
               #1 req = 4'b0000;
            end
            17: check("blink2_done_k17", 32'(done), 32'h0);
            18: check("blink2_busy_k18", 32'(busy), 32'h0);
            default: ;
         endcase
      end

      // Owner 2 aborts during OFF while requester 3 waits.
      @(negedge clk);
      #1 req = 4'b1100; req_count = 16'h1100;
      @(negedge clk);
      check("abort_grant_k", 32'(grant), 32'h4);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         case (j)
            4: check("abort_led_k4", 32'(led), 32'h0);
            5: begin
               check("abort_grant_k5", 32'(grant), 32'h4);
               #1 req = 4'b1000;
            end
            6: begin
               check("abort_grant_k6", 32'(grant), 32'h0);
               check("abort_done_k6",  32'(done),  32'h0);
               check("abort_busy_k6",  32'(busy),  32'h1);
            end
            8: check("abort_busy_k8", 32'(busy), 32'h0);
            9: begin
               check("abort_next_grant_k9", 32'(grant), 32'h8);
               check("abort_next_led_k9",   32'(led),   32'h1);
               #1 req = 4'b0000;
            end
            default: ;
         endcase
      end
      repeat (4) @(negedge clk);

      // Zero-count request: one-cycle grant and done, LED never lights.
      #1 req = 4'b0100; req_count = 16'h0000;
      @(negedge clk);
      check("zero_grant_k", 32'(grant), 32'h4);
      check("zero_done_k",  32'(done),  32'h4);
      check("zero_led_k",   32'(led),   32'h0);
      check("zero_busy_k",  32'(busy),  32'h1);
      #1 req = 4'b0000;
      @(negedge clk);
      check("zero_grant_k1", 32'(grant), 32'h0);
      check("zero_done_k1",  32'(done),  32'h0);
      check("zero_busy_k1",  32'(busy),  32'h1);
      @(negedge clk);
      check("zero_busy_k2", 32'(busy), 32'h0);

      // Asynchronous reset mid-ON, then lone requester 3 is served despite ptr=3.
      #1 req = 4'b0001; req_count = 16'h1003;
      @(negedge clk);
      check("areset_grant_before", 32'(grant), 32'h1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("areset_led",   32'(led),   32'h0);
      check("areset_grant", 32'(grant), 32'h0);
      check("areset_busy",  32'(busy),  32'h0);
      req = 4'b1000;
      #1 rst = 1'b0;
      @(negedge clk);
      check("areset_lone3_grant", 32'(grant), 32'h8);
      check("areset_lone3_led",   32'(led),   32'h1);
      #1 req = 4'b0000;
      repeat (4) @(negedge clk);

      // Held 1111 with count 1 from reset: strict rotation, 11-cycle pitch.
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0; req = 4'b1111; req_count = 16'h1111;
      for (int j = 0; j <= 44; j++) begin
         @(negedge clk);
         if (j % 11 == 0)
            check("rotate_grant", 32'(grant), 32'(1 << ((j / 11) % 4)));
         else if (j % 11 == 8)
            check("rotate_gap_grant", 32'(grant), 32'h0);
      end

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         if ($urandom_range(0, 15) == 0)
            for (int i = 0; i < 4; i++) req_count[4*i +: 4] = 4'($urandom_range(0, 3));
      end
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
